pipe_stage_regs: RTL

Carries decoded instruction control fields from decode through EX, MEM and RB, and produces the per-stage opcode/func buses consumed by the control unit. It sits directly upstream of the control unit. It also owns load-use stall detection and branch/jump squash, so the control unit always sees clean, bubble-safe stage contents. Each stage is one registered slot with a valid bit; an invalid slot is a bubble.

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/stage_slot.sv | 31 +++
 rtl/pipe_stage_regs.sv | 121 ++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared stage-slot type and opcode constants for the decode-to-writeback
// control pipeline and the control unit downstream of it.
package pipe_pkg;

   typedef struct packed {
      logic       valid;
      logic [5:0] opcode;
      logic [5:0] func;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] rd;
   } stage_t;

   // All-zero decodes to no write, no branch and no memory write downstream.
   localparam stage_t BUBBLE = '0;

   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_J   = 6'h02;
   localparam logic [5:0] OP_JAL = 6'h03;

endpackage

// File: rtl/stage_slot.sv
// One registered pipeline slot. Priority: hold > bubble > load; an invalid
// slot always presents the bubble encoding.
module stage_slot
   import pipe_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   hold,
   input  logic   bubble,
   input  logic   load,
   input  stage_t d,
   output stage_t q
);

   stage_t slotQ;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slotQ <= BUBBLE;
      end else if (!hold) begin
         if (bubble) begin
            slotQ <= BUBBLE;
         end else if (load) begin
            slotQ <= d.valid ? d : BUBBLE;
         end
      end
   end

   assign q = slotQ.valid ? slotQ : BUBBLE;

endmodule

// File: rtl/pipe_stage_regs.sv
// EX/MEM/RB control-field pipeline with load-use stall, redirect squash and
// saturating event counters, feeding the control unit clean stage contents.
module pipe_stage_regs
   import pipe_pkg::*;
#(
   parameter logic [5:0]  LOAD_OP = OP_LW,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [5:0]       id_opcode,
   input  logic [5:0]       id_func,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic [4:0]       id_rd,
   input  logic [1:0]       pc_src,
   input  logic             hold,
   output logic             stall,
   output logic             flush_id,
   output logic [5:0]       ex_opcode,
   output logic [5:0]       ex_func,
   output logic [4:0]       ex_rs,
   output logic [4:0]       ex_rt,
   output logic [4:0]       ex_rd,
   output logic             ex_valid,
   output logic [5:0]       mem_opcode,
   output logic [5:0]       mem_func,
   output logic [4:0]       mem_rd,
   output logic             mem_valid,
   output logic [5:0]       rb_opcode,
   output logic [4:0]       rb_rd,
   output logic             rb_valid,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] squash_cnt
);

   stage_t idSlot;
   stage_t exQ;
   stage_t memQ;
   stage_t rbQ;
   logic   redirect;
   logic   loadUse;
   logic   unusedBits;

   logic [CNT_W-1:0] stallCntQ;
   logic [CNT_W-1:0] squashCntQ;

   assign idSlot = {id_valid, id_opcode, id_func, id_rs, id_rt, id_rd};

   assign redirect = (pc_src != 2'b00);
   assign loadUse  = exQ.valid & (exQ.opcode == LOAD_OP) & id_valid & (exQ.rt != 5'd0)
                   & ((exQ.rt == id_rs) | (exQ.rt == id_rt));

   // A redirect squashes the dependent instruction, so it never also stalls.
   assign stall    = (loadUse & ~redirect) | hold;
   assign flush_id = redirect;

   stage_slot uEx (
      .clk    (clk),
      .rst_n  (rst_n),
      .hold   (hold),
      .bubble (redirect | loadUse),
      .load   (1'b1),
      .d      (idSlot),
      .q      (exQ)
   );

   stage_slot uMem (
      .clk    (clk),
      .rst_n  (rst_n),
      .hold   (hold),
      .bubble (redirect),
      .load   (1'b1),
      .d      (exQ),
      .q      (memQ)
   );

   stage_slot uRb (
      .clk    (clk),
      .rst_n  (rst_n),
      .hold   (hold),
      .bubble (1'b0),
      .load   (1'b1),
      .d      (memQ),
      .q      (rbQ)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stallCntQ  <= '0;
         squashCntQ <= '0;
      end else if (!hold) begin
         if (redirect) begin
            if (!(&squashCntQ)) squashCntQ <= squashCntQ + CNT_W'(1);
         end else if (loadUse) begin
            if (!(&stallCntQ)) stallCntQ <= stallCntQ + CNT_W'(1);
         end
      end
   end

   assign ex_opcode  = exQ.opcode;
   assign ex_func    = exQ.func;
   assign ex_rs      = exQ.rs;
   assign ex_rt      = exQ.rt;
   assign ex_rd      = exQ.rd;
   assign ex_valid   = exQ.valid;
   assign mem_opcode = memQ.opcode;
   assign mem_func   = memQ.func;
   assign mem_rd     = memQ.rd;
   assign mem_valid  = memQ.valid;
   assign rb_opcode  = rbQ.opcode;
   assign rb_rd      = rbQ.rd;
   assign rb_valid   = rbQ.valid;
   assign stall_cnt  = stallCntQ;
   assign squash_cnt = squashCntQ;

   // Writeback only needs opcode and rd; the rest of the slot is carried for uniformity.
   assign unusedBits = ^{rbQ.func, rbQ.rs, rbQ.rt};

endmodule
